// File: rtl/pipeline_trace_monitor_if.sv
// Trace read channel between the monitor (master) and the debug host (slave).
// First-word-fall-through: the o_rd_* fields carry the FIFO head whenever o_rd_valid is high.
interface pipeline_trace_monitor_if #(
    parameter int XLEN = 32
);
    logic            i_rd_ready;
    logic            o_rd_valid;
    logic [XLEN-1:0] o_rd_pc;
    logic [31:0]     o_rd_instr;
    logic [4:0]      o_rd_rd;
    logic [XLEN-1:0] o_rd_data;

    modport master (
        input  i_rd_ready,
        output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_rd, o_rd_data
    );
    modport slave (
        output i_rd_ready,
        input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_rd, o_rd_data
    );
endinterface

// File: rtl/pipeline_trace_monitor.sv
// Run-time monitor beside the 5-stage datapath: saturating perf counters, retired-instruction
// trace FIFO drained by a debug host, and a status FSM for halt detection and cycle timeout.
module pipeline_trace_monitor #(
    parameter int XLEN     = 32,
    parameter int CNT_W    = 32,
    parameter int DEPTH    = 16,
    parameter int HALT_REG = 20,
    parameter int HALT_VAL = 100,
    parameter int TIMEOUT  = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [1:0]        i_forwardA,
    input  logic [1:0]        i_forwardB,
    input  logic              i_wb_valid,
    input  logic [XLEN-1:0]   i_wb_pc,
    input  logic [31:0]       i_wb_instr,
    input  logic              i_wb_regwrite,
    input  logic [4:0]        i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    pipeline_trace_monitor_if.master trace,
    output logic [CNT_W-1:0]  o_cycles,
    output logic [CNT_W-1:0]  o_retired,
    output logic [CNT_W-1:0]  o_stalls,
    output logic [CNT_W-1:0]  o_flushes,
    output logic [CNT_W-1:0]  o_forwards,
    output logic [CNT_W-1:0]  o_dropped,
    output logic              o_overflow,
    output logic [1:0]        o_state,
    output logic              o_done,
    output logic              o_timeout
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, TMO = 2'd3} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

    state_t          state;
    rec_t            mem [DEPTH];
    rec_t            rec_in, head;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            run, empty, full, push_req, push, pop, drop;
    logic            halt_hit, tmo_hit;
    logic [CNT_W-1:0] cycles_nxt;

    assign run = (state == RUN);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = run && i_wb_valid;
    assign pop      = !empty && trace.i_rd_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign rec_in = '{pc:    i_wb_pc,
                      instr: i_wb_instr,
                      rd:    i_wb_regwrite ? i_wb_rd : 5'd0,
                      data:  i_wb_regwrite ? i_wb_data : '0};
    assign head   = mem[rd_ptr[AW-1:0]];

    assign trace.o_rd_valid = !empty;
    assign trace.o_rd_pc    = empty ? '0    : head.pc;
    assign trace.o_rd_instr = empty ? 32'd0 : head.instr;
    assign trace.o_rd_rd    = empty ? 5'd0  : head.rd;
    assign trace.o_rd_data  = empty ? '0    : head.data;

    assign halt_hit = (HALT_REG != 0) && run && i_wb_valid && i_wb_regwrite &&
                      (i_wb_rd == 5'(HALT_REG)) && (i_wb_data == XLEN'(HALT_VAL));
    assign cycles_nxt = sat_inc(o_cycles, 1'b1);
    assign tmo_hit    = (TIMEOUT != 0) && run && (cycles_nxt == CNT_W'(TIMEOUT));

    assign o_state   = state;
    assign o_done    = (state == DONE);
    assign o_timeout = (state == TMO);

    // Storage needs no reset: the read mux forces zeros while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_cycles   <= '0;
            o_retired  <= '0;
            o_stalls   <= '0;
            o_flushes  <= '0;
            o_forwards <= '0;
            o_dropped  <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) o_overflow <= 1'b1;
            if (run) begin
                o_cycles   <= cycles_nxt;
                o_retired  <= sat_inc(o_retired, i_wb_valid);
                o_stalls   <= sat_inc(o_stalls, i_stall);
                o_flushes  <= sat_inc(o_flushes, i_flush);
                o_forwards <= sat_inc(o_forwards, |{i_forwardA, i_forwardB});
                o_dropped  <= sat_inc(o_dropped, drop);
            end
            // Halt outranks timeout; both outrank a pause in the same cycle.
            case (state)
                IDLE: if (i_enable) state <= RUN;
                RUN: begin
                    if (halt_hit)       state <= DONE;
                    else if (tmo_hit)   state <= TMO;
                    else if (!i_enable) state <= IDLE;
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed bench for pipeline_trace_monitor: reset, counters, FIFO overflow/drain, halt, timeout,
// plus a narrow-counter instance to exercise saturation.
module tb_pipeline_trace_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable, i_stall, i_flush, i_wb_valid, i_wb_regwrite;
    logic [1:0]  i_forwardA, i_forwardB;
    logic [31:0] i_wb_pc, i_wb_instr, i_wb_data;
    logic [4:0]  i_wb_rd;

    logic [31:0] o_cycles, o_retired, o_stalls, o_flushes, o_forwards, o_dropped;
    logic        o_overflow, o_done, o_timeout;
    logic [1:0]  o_state;

    logic [2:0]  s_cycles, s_retired, s_stalls, s_flushes, s_forwards, s_dropped;
    logic        s_overflow, s_done, s_timeout;
    logic [1:0]  s_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipeline_trace_monitor_if #(.XLEN(32)) trace ();
    pipeline_trace_monitor_if #(.XLEN(32)) trace_s ();

    pipeline_trace_monitor dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_stall(i_stall), .i_flush(i_flush),
        .i_forwardA(i_forwardA), .i_forwardB(i_forwardB), .i_wb_valid(i_wb_valid),
        .i_wb_pc(i_wb_pc), .i_wb_instr(i_wb_instr), .i_wb_regwrite(i_wb_regwrite),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .trace(trace),
        .o_cycles(o_cycles), .o_retired(o_retired), .o_stalls(o_stalls), .o_flushes(o_flushes),
        .o_forwards(o_forwards), .o_dropped(o_dropped), .o_overflow(o_overflow),
        .o_state(o_state), .o_done(o_done), .o_timeout(o_timeout));

    pipeline_trace_monitor #(.CNT_W(3), .HALT_REG(0), .TIMEOUT(0)) dut_sat (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_stall(i_stall), .i_flush(i_flush),
        .i_forwardA(i_forwardA), .i_forwardB(i_forwardB), .i_wb_valid(i_wb_valid),
        .i_wb_pc(i_wb_pc), .i_wb_instr(i_wb_instr), .i_wb_regwrite(i_wb_regwrite),
        .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .trace(trace_s),
        .o_cycles(s_cycles), .o_retired(s_retired), .o_stalls(s_stalls), .o_flushes(s_flushes),
        .o_forwards(s_forwards), .o_dropped(s_dropped), .o_overflow(s_overflow),
        .o_state(s_state), .o_done(s_done), .o_timeout(s_timeout));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle_inputs();
        i_stall = 0; i_flush = 0; i_forwardA = 0; i_forwardB = 0;
        i_wb_valid = 0; i_wb_regwrite = 0; i_wb_rd = 0; i_wb_data = 0;
        i_wb_pc = 0; i_wb_instr = 0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                          input logic [4:0] rd, input logic [31:0] data);
        i_wb_valid = 1; i_wb_pc = pc; i_wb_instr = instr;
        i_wb_regwrite = rw; i_wb_rd = rd; i_wb_data = data;
    endtask

    task automatic do_reset();
        reset = 1; i_enable = 0; trace.i_rd_ready = 0; idle_inputs();
        tick();
        reset = 0;
        tick();
    endtask

    initial begin
        reset = 1; i_enable = 0; trace.i_rd_ready = 0; trace_s.i_rd_ready = 0; idle_inputs();
        tick(2);
        reset = 0;
        tick();

        // 1: reset mid-run with 5 entries queued
        i_enable = 1; tick();
        for (int i = 0; i < 5; i++) begin
            retire(32'h100 + 4 * i, 32'h13, 1, 5'd3, 32'd7 + i);
            tick();
        end
        chk("pre_reset_cycles", o_cycles, 5);
        chk("pre_reset_valid", trace.o_rd_valid, 1);
        reset = 1;
        tick();
        chk("rst_state", o_state, 0);
        chk("rst_valid", trace.o_rd_valid, 0);
        chk("rst_pc", trace.o_rd_pc, 0);
        chk("rst_counters", {o_cycles | o_retired | o_stalls | o_flushes | o_forwards | o_dropped}, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_done_tmo", {o_done, o_timeout}, 0);
        reset = 0; idle_inputs(); i_enable = 0;
        tick();

        // 2: ten RUN cycles of mixed hazard activity
        i_enable = 1; tick();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            retire(32'h200 + 4 * i, 32'h33, 0, 5'd0, 32'd0);
            i_stall = (i == 2 || i == 3);
            i_flush = (i == 5);
            if (i == 7) begin i_forwardA = 2'd2; i_forwardB = 2'd1; end
            tick();
        end
        chk("t2_cycles", o_cycles, 10);
        chk("t2_retired", o_retired, 10);
        chk("t2_stalls", o_stalls, 2);
        chk("t2_flushes", o_flushes, 1);
        chk("t2_forwards", o_forwards, 1);
        chk("t2_head_pc", trace.o_rd_pc, 32'h200);
        chk("sat_cycles", s_cycles, 7);
        chk("sat_retired", s_retired, 7);
        chk("sat_stalls", s_stalls, 2);
        do_reset();

        // 3: overflow with reader stalled, then in-order drain
        i_enable = 1; tick();
        for (int i = 0; i < 20; i++) begin
            retire(32'h1000 + 4 * i, i, (i % 2) == 0, 5'(i + 1), 32'hA000 + i);
            tick();
        end
        idle_inputs(); i_enable = 0; tick();
        chk("t3_retired", o_retired, 20);
        chk("t3_dropped", o_dropped, 4);
        chk("t3_overflow", o_overflow, 1);
        trace.i_rd_ready = 1;
        for (int k = 0; k < 16; k++) begin
            chk("t3_drain_valid", trace.o_rd_valid, 1);
            chk("t3_drain_pc", trace.o_rd_pc, 32'h1000 + 4 * k);
            chk("t3_drain_rd", trace.o_rd_rd, (k % 2 == 0) ? k + 1 : 0);
            chk("t3_drain_data", trace.o_rd_data, (k % 2 == 0) ? 32'hA000 + k : 0);
            tick();
        end
        chk("t3_empty_valid", trace.o_rd_valid, 0);
        chk("t3_empty_pc", trace.o_rd_pc, 0);
        chk("t3_overflow_sticky", o_overflow, 1);
        do_reset();

        // 4: full FIFO, push and pop together
        i_enable = 1; tick();
        for (int i = 0; i < 16; i++) begin
            retire(32'h2000 + 4 * i, 32'h13, 0, 5'd0, 32'd0);
            tick();
        end
        retire(32'h2040, 32'h13, 0, 5'd0, 32'd0);
        trace.i_rd_ready = 1;
        chk("t4_head_before", trace.o_rd_pc, 32'h2000);
        tick();
        trace.i_rd_ready = 0; idle_inputs(); i_enable = 0;
        chk("t4_head_after", trace.o_rd_pc, 32'h2004);
        tick();
        chk("t4_dropped", o_dropped, 0);
        chk("t4_overflow", o_overflow, 0);
        begin
            int n = 0;
            logic [31:0] last = 0;
            trace.i_rd_ready = 1;
            for (int g = 0; g < 20 && trace.o_rd_valid; g++) begin
                last = trace.o_rd_pc; n++;
                tick();
            end
            chk("t4_occupancy", n, 16);
            chk("t4_last_pc", last, 32'h2040);
        end
        do_reset();

        // 5: halt on addi x20,x0,100
        i_enable = 1; tick();
        retire(32'h3000, 32'h00500293, 1, 5'd5, 32'd5); tick();
        retire(32'h3004, 32'h00700313, 1, 5'd20, 32'd7); tick();
        retire(32'h3008, 32'h06400A13, 1, 5'd20, 32'd100); tick();
        chk("t5_done", o_done, 1);
        chk("t5_state", o_state, 2);
        chk("t5_timeout", o_timeout, 0);
        chk("t5_retired", o_retired, 3);
        retire(32'h300C, 32'h13, 0, 5'd0, 32'd0); tick();
        chk("t5_retired_frozen", o_retired, 3);
        chk("t5_cycles_frozen", o_cycles, 3);
        idle_inputs();
        trace.i_rd_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_drain_pc", trace.o_rd_pc, 32'h3000 + 4 * k);
            if (k == 2) begin
                chk("t5_halt_rd", trace.o_rd_rd, 20);
                chk("t5_halt_data", trace.o_rd_data, 100);
            end
            tick();
        end
        chk("t5_no_post_halt_trace", trace.o_rd_valid, 0);
        do_reset();

        // 6a: timeout after exactly 80 RUN cycles
        i_enable = 1; tick();
        tick(79);
        chk("t6a_79_tmo", o_timeout, 0);
        chk("t6a_79_cycles", o_cycles, 79);
        tick();
        chk("t6a_80_tmo", o_timeout, 1);
        chk("t6a_80_state", o_state, 3);
        tick();
        chk("t6a_hold_cycles", o_cycles, 80);
        do_reset();

        // 6b: a 10-cycle pause delays the timeout by 10 cycles
        i_enable = 1; tick();
        tick(30);
        i_enable = 0; tick(10);
        chk("t6b_paused_state", o_state, 0);
        chk("t6b_paused_cycles", o_cycles, 31);
        i_enable = 1; tick(49);
        chk("t6b_tmo_early", o_timeout, 0);
        chk("t6b_cycles", o_cycles, 79);
        tick();
        chk("t6b_tmo", o_timeout, 1);
        do_reset();

        // 6c: halt and timeout in the same cycle -> DONE
        i_enable = 1; tick();
        tick(79);
        retire(32'h4000, 32'h06400A13, 1, 5'd20, 32'd100); tick();
        idle_inputs();
        chk("t6c_done", o_done, 1);
        chk("t6c_timeout", o_timeout, 0);
        chk("t6c_cycles", o_cycles, 80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_trace_monitor.md
Name: pipeline_trace_monitor

Overview:
Synthesizable run-time monitor that sits beside the 5-stage RISC-V datapath. It observes hazard and write-back signals, keeps saturating performance counters and buffers retired-instruction records in a trace FIFO that a debug host drains with a valid/ready handshake. It also detects the end-of-program condition (a configured register written with a configured value) and a cycle-count timeout, and reports both through a status FSM.

Parameters:
XLEN, 32, data width of write-back value and PC/instruction fields
CNT_W, 32, width of every performance counter (saturating)
DEPTH, 16, trace FIFO entries; power of 2, >= 2
HALT_REG, 20, destination register that signals completion; 0 disables halt detection
HALT_VAL, 100, value that, written to HALT_REG, signals completion
TIMEOUT, 80, RUN cycles before timeout; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_enable  in  1  1 = monitor runs; 0 = pause
i_stall  in  1  load-use stall this cycle
i_flush  in  1  branch flush this cycle
i_forwardA  in  2  forwarding select, operand A
i_forwardB  in  2  forwarding select, operand B
i_wb_valid  in  1  non-bubble instruction retiring in WB
i_wb_pc  in  XLEN  PC of retiring instruction
i_wb_instr  in  32  retiring instruction word
i_wb_regwrite  in  1  retiring instruction writes rd
i_wb_rd  in  5  destination register
i_wb_data  in  XLEN  write-back value
i_rd_ready  in  1  host accepts trace head
o_rd_valid  out  1  trace head valid
o_rd_pc  out  XLEN  head PC
o_rd_instr  out  32  head instruction
o_rd_rd  out  5  head rd (0 if no regwrite)
o_rd_data  out  XLEN  head write-back value (0 if no regwrite)
o_cycles, o_retired, o_stalls, o_flushes, o_forwards, o_dropped  out  CNT_W each  counters
o_overflow  out  1  sticky: at least one trace record dropped
o_state  out  2  0 IDLE, 1 RUN, 2 DONE, 3 TIMEOUT
o_done  out  1  o_state==DONE
o_timeout  out  1  o_state==TIMEOUT

Behaviour:
- Reset (async, any time, including mid-run): state IDLE, all counters 0, FIFO empty, o_rd_valid 0, o_rd_* 0, o_overflow 0, o_done/o_timeout 0.
- FSM: IDLE->RUN when i_enable=1. RUN->IDLE when i_enable=0; counters and FIFO are retained. RUN->DONE on halt hit. RUN->TIMEOUT when the increment makes o_cycles equal TIMEOUT. If halt and timeout occur in the same cycle, DONE wins. DONE and TIMEOUT hold until reset.
- Counters update only in cycles where state==RUN at the clock edge. All updates are registered, 1-cycle latency.
- o_cycles +1 every RUN cycle.
- o_retired +1 per i_wb_valid.
- o_stalls +1 per i_stall.
- o_flushes +1 per i_flush.
- o_forwards +1 per cycle with i_forwardA!=0 or i_forwardB!=0 (once per cycle, not per operand).
- All counters saturate at 2^CNT_W-1 and never wrap.
- Halt hit: RUN & i_wb_valid & i_wb_regwrite & i_wb_rd==HALT_REG & i_wb_data==HALT_VAL & HALT_REG!=0. The hitting instruction is still counted and traced.
- Trace push: RUN & i_wb_valid. The record is {pc, instr, regwrite ? rd : 0, regwrite ? data : 0}.
- Trace pop: o_rd_valid & i_rd_ready. The FIFO is first-word-fall-through: o_rd_* shows the head whenever o_rd_valid=1 and is 0 when empty. Draining continues in every state, including IDLE, DONE and TIMEOUT.
- Full FIFO with push and no pop: the record is dropped, o_dropped +1 (saturating), o_overflow set (sticky until reset).
- Full FIFO with simultaneous push and pop: both proceed, nothing dropped.
- Empty FIFO with simultaneous push and pop: the pop is ignored (o_rd_valid=0), the push proceeds.
- Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty are derived from the MSB compare.

Test Plan:
1. Reset mid-run with 5 entries queued -> next cycle o_state=0, o_rd_valid=0, every counter 0, o_overflow=0.
2. Enable; 10 cycles with i_wb_valid=1 every cycle, i_stall=1 in 2 cycles, i_flush=1 in 1 cycle, i_forwardA=2 & i_forwardB=1 in the same cycle -> o_cycles=10, o_retired=10, o_stalls=2, o_flushes=1, o_forwards=1.
3. DEPTH=16, i_rd_ready=0, 20 valid retirements -> 16 entries held, o_dropped=4, o_overflow=1. Then assert i_rd_ready -> the 16 oldest PCs are read out in order.
4. Full FIFO, push and pop in the same cycle -> o_dropped unchanged, occupancy stays 16, head advances by one.
5. Retire addi x20,x0,100 (rd=20, data=100, regwrite=1) -> the record is traced, o_done=1 next cycle, later retirements are not counted.
6. TIMEOUT=80, no halt -> o_timeout=1 after exactly 80 RUN cycles. Pausing i_enable=0 for 10 cycles mid-run delays the timeout by 10 cycles. Halt on cycle 80 -> o_done=1, not o_timeout.
